rps_round_ctrl: RTL

//  Rock-paper-scissors round controller; feeds two seg7 digit decoders (digit1 = player 1, digit0 = player 2).

---
 rtl/rps_pkg.sv | 46 ++++
 rtl/rps_edge_det.sv | 24 ++
 rtl/rps_round_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rps_pkg.sv
// Shared types, display codes and scoring helper
// for the rock-paper-scissors round controller.
package rps_pkg;

    typedef enum logic [1:0] {
        TH_R   = 2'd0,
        TH_P   = 2'd1,
        TH_S   = 2'd2,
        TH_INV = 2'd3
    } throw_t;

    typedef enum logic [1:0] {
        ARM    = 2'd0,
        REVEAL = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [3:0] CODE_R     = 4'd0;
    localparam logic [3:0] CODE_P     = 4'd1;
    localparam logic [3:0] CODE_S     = 4'd2;
    localparam logic [3:0] CODE_WIN   = 4'd3;
    localparam logic [3:0] CODE_WAIT  = 4'd4;
    localparam logic [3:0] CODE_LOSE  = 4'd5;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    function automatic logic [1:0] rps_judge(throw_t a, throw_t b);
        logic [1:0] w;
        w = WIN_P2;
        if (a == b)
            w = WIN_NONE;
        else if ((a == TH_R && b == TH_S) ||
                 (a == TH_S && b == TH_P) ||
                 (a == TH_P && b == TH_R))
            w = WIN_P1;
        return w;
    endfunction

    function automatic logic [3:0] throw_code(throw_t t);
        return {2'b00, t};
    endfunction

endpackage

// File: rtl/rps_edge_det.sv
// Registered rising-edge detector, one pulse per
// 0->1 transition of each input bit.
module rps_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= '0;
            rise <= '0;
        end else begin
            prev <= d;
            rise <= d & ~prev;
        end
    end

endmodule

// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors round controller: latch throws,
// reveal, score, hold result, re-arm.
module rps_round_ctrl
    import rps_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         p1_sel,
    input  logic               p1_lock,
    input  logic [1:0]         p2_sel,
    input  logic               p2_lock,
    output logic [3:0]         bcd1,
    output logic [3:0]         bcd0,
    output logic [1:0]         winner,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               round_done
);

    localparam int TW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] TLOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SMAX = {SCORE_W{1'b1}};

    logic e1, e2;

    rps_edge_det #(.W(1)) u_edge1 (
        .clk   (clk),
        .reset (reset),
        .d     (p1_lock),
        .rise  (e1)
    );

    rps_edge_det #(.W(1)) u_edge2 (
        .clk   (clk),
        .reset (reset),
        .d     (p2_lock),
        .rise  (e2)
    );

    state_t             st_q, st_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    throw_t             th1_q, th1_d;
    throw_t             th2_q, th2_d;
    logic               lk1_q, lk1_d;
    logic               lk2_q, lk2_d;
    logic [1:0]         win_q, win_d;
    logic [SCORE_W-1:0] sc1_q, sc1_d;
    logic [SCORE_W-1:0] sc2_q, sc2_d;
    logic               done_q, done_d;
    logic [3:0]         b1_q, b1_d;
    logic [3:0]         b0_q, b0_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= ARM;
            tmr_q  <= '0;
            th1_q  <= TH_R;
            th2_q  <= TH_R;
            lk1_q  <= 1'b0;
            lk2_q  <= 1'b0;
            win_q  <= WIN_NONE;
            sc1_q  <= '0;
            sc2_q  <= '0;
            done_q <= 1'b0;
            b1_q   <= CODE_WAIT;
            b0_q   <= CODE_WAIT;
        end else begin
            st_q   <= st_d;
            tmr_q  <= tmr_d;
            th1_q  <= th1_d;
            th2_q  <= th2_d;
            lk1_q  <= lk1_d;
            lk2_q  <= lk2_d;
            win_q  <= win_d;
            sc1_q  <= sc1_d;
            sc2_q  <= sc2_d;
            done_q <= done_d;
            b1_q   <= b1_d;
            b0_q   <= b0_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        tmr_d  = tmr_q;
        th1_d  = th1_q;
        th2_d  = th2_q;
        lk1_d  = lk1_q;
        lk2_d  = lk2_q;
        win_d  = win_q;
        sc1_d  = sc1_q;
        sc2_d  = sc2_q;
        done_d = 1'b0;
        b1_d   = b1_q;
        b0_d   = b0_q;

        unique case (st_q)
            ARM: begin
                if (e1 && !lk1_q && p1_sel != 2'd3) begin
                    th1_d = throw_t'(p1_sel);
                    lk1_d = 1'b1;
                end
                if (e2 && !lk2_q && p2_sel != 2'd3) begin
                    th2_d = throw_t'(p2_sel);
                    lk2_d = 1'b1;
                end
                // The final lock and the reveal land on the same edge
                if (lk1_d && lk2_d) begin
                    st_d  = REVEAL;
                    tmr_d = TLOAD;
                    b1_d  = throw_code(th1_d);
                    b0_d  = throw_code(th2_d);
                end else begin
                    b1_d = lk1_d ? CODE_BLANK : CODE_WAIT;
                    b0_d = lk2_d ? CODE_BLANK : CODE_WAIT;
                end
            end
            REVEAL: begin
                if (tmr_q == '0) begin
                    st_d   = RESULT;
                    tmr_d  = TLOAD;
                    done_d = 1'b1;
                    win_d  = rps_judge(th1_q, th2_q);
                    unique case (1'b1)
                        (win_d == WIN_P1): begin
                            b1_d = CODE_WIN;
                            b0_d = CODE_LOSE;
                            if (sc1_q != SMAX)
                                sc1_d = sc1_q + SCORE_W'(1);
                        end
                        (win_d == WIN_P2): begin
                            b1_d = CODE_LOSE;
                            b0_d = CODE_WIN;
                            if (sc2_q != SMAX)
                                sc2_d = sc2_q + SCORE_W'(1);
                        end
                        default: begin
                            b1_d = CODE_WAIT;
                            b0_d = CODE_WAIT;
                        end
                    endcase
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            RESULT: begin
                if (tmr_q == '0) begin
                    st_d  = ARM;
                    lk1_d = 1'b0;
                    lk2_d = 1'b0;
                    win_d = WIN_NONE;
                    b1_d  = CODE_WAIT;
                    b0_d  = CODE_WAIT;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: begin
                st_d  = ARM;
                lk1_d = 1'b0;
                lk2_d = 1'b0;
                win_d = WIN_NONE;
                b1_d  = CODE_WAIT;
                b0_d  = CODE_WAIT;
            end
        endcase
    end

    assign bcd1       = b1_q;
    assign bcd0       = b0_q;
    assign winner     = win_q;
    assign p1_score   = sc1_q;
    assign p2_score   = sc2_q;
    assign round_done = done_q;

endmodule
